// File: rtl/mult_acc_2bits.sv
// rtl/mult_acc_2bits.sv - saturating accumulator of LEN signed 2-bit-multiplier products.
// The result is held with a valid/ready handshake until it is consumed.
module mult_acc_2bits #(
   parameter int LEN   = 9,
   parameter int ACC_W = 10
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clr,
   input  logic                    in_valid,
   input  logic signed [4:0]       in_mul,
   output logic                    in_ready,
   output logic                    out_valid,
   output logic signed [ACC_W-1:0] out_sum,
   output logic                    out_sat,
   input  logic                    out_ready
);

   typedef enum logic {ACC, HOLD} state_t;

   localparam logic [7:0] LAST = 8'(LEN - 1);

   state_t                  state, state_nxt;
   logic signed [ACC_W-1:0] acc;
   logic [7:0]              cnt;
   logic                    sat_flag;
   logic signed [ACC_W:0]   sum_wide;
   logic signed [ACC_W-1:0] sum_sat;
   logic                    clamp;
   logic                    accept;
   logic                    last;

   assign in_ready  = (state == ACC);
   assign out_valid = (state == HOLD);
   assign accept    = in_valid && (state == ACC);
   assign last      = (cnt == LAST);
   assign sum_wide  = {acc[ACC_W-1], acc} + {{(ACC_W-4){in_mul[4]}}, in_mul};

   // One guard bit is enough: a 5-bit product cannot overflow by more than one bit.
   always_comb begin
      clamp   = 1'b0;
      sum_sat = sum_wide[ACC_W-1:0];
      if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
         clamp   = 1'b1;
         sum_sat = sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                   : {1'b0, {(ACC_W-1){1'b1}}};
      end
   end

   always_comb begin
      state_nxt = state;
      if (clr) begin
         state_nxt = ACC;
      end else begin
         case (state)
            ACC:  if (accept && last) state_nxt = HOLD;
            HOLD: if (out_ready)      state_nxt = ACC;
            default:                  state_nxt = ACC;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ACC;
      else        state <= state_nxt;
   end

   // out_sum/out_sat are only written on the last product, so they survive handshakes and clr.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc      <= '0;
         cnt      <= '0;
         sat_flag <= 1'b0;
         out_sum  <= '0;
         out_sat  <= 1'b0;
      end else if (clr || (state == HOLD && out_ready)) begin
         acc      <= '0;
         cnt      <= '0;
         sat_flag <= 1'b0;
      end else if (accept) begin
         acc      <= sum_sat;
         sat_flag <= sat_flag | clamp;
         if (last) begin
            cnt     <= '0;
            out_sum <= sum_sat;
            out_sat <= sat_flag | clamp;
         end else begin
            cnt     <= cnt + 8'd1;
         end
      end
   end

endmodule

// File: doc/mult_acc_2bits.md
MULT_ACC_2BITS -- requirements
Module: mult_acc_2bits

Interface
REQ-001 Parameter: LEN, default 9, number of products accumulated per window (3x3 kernel), legal range 2..255.
REQ-002 Parameter: ACC_W, default 10, signed accumulator and result width, legal range 6..32.
REQ-003 Port: clk  input  1  single clock, all state updates on its rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: clr  input  1  synchronous window abort and clear.
REQ-006 Port: in_valid  input  1  product present on in_mul.
REQ-007 Port: in_mul  input  5  signed two's-complement product from the 2-bit signed x unsigned multiplier stage, range -12..+9.
REQ-008 Port: in_ready  output  1  block accepts in_mul this cycle.
REQ-009 Port: out_valid  output  1  window result present on out_sum.
REQ-010 Port: out_sum  output  ACC_W  signed window sum.
REQ-011 Port: out_sat  output  1  saturation occurred at least once in this window.
REQ-012 Port: out_ready  input  1  consumer accepts out_sum this cycle.

Function
REQ-013 The block SHALL implement two states: ACC (collecting products) and HOLD (result presented).
REQ-014 In ACC, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-015 In HOLD, in_ready SHALL be 0 and out_valid SHALL be 1.
REQ-016 A product SHALL be accepted when in_valid and in_ready are both 1 on a rising clk edge.
REQ-017 On acceptance, acc SHALL become sat(acc + sext(in_mul)) and cnt SHALL increment by 1.
REQ-018 sat() SHALL clamp the sum to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; when a clamp occurs, the sticky sat flag SHALL be set.
REQ-019 When the accepted product is number LEN (cnt == LEN-1 before acceptance), the state SHALL move to HOLD on that edge.
REQ-020 On entering HOLD, out_sum SHALL carry the final saturated sum and out_sat the sticky flag, with latency 1 clk after the last product edge.
REQ-021 out_sum and out_sat SHALL be registered and stable while in HOLD.
REQ-022 In HOLD with out_ready=1, the state SHALL return to ACC on that edge, with acc=0, cnt=0 and sat flag=0.
REQ-023 In HOLD with out_ready=0, the state SHALL remain HOLD indefinitely.
REQ-024 in_valid asserted in HOLD SHALL be ignored, with no state change.
REQ-025 clr=1 SHALL force state ACC, acc=0, cnt=0, sat flag=0 and out_valid=0 on that edge, taking priority over acceptance and out_ready.
REQ-026 out_sum and out_sat SHALL hold their last values after a handshake, and SHALL be cleared only by reset.
REQ-027 A gap in in_valid SHALL leave acc and cnt unchanged.
REQ-028 A window SHALL complete exactly at LEN accepted products; cnt SHALL never exceed LEN-1.

Reset
REQ-029 rst_n=0 SHALL immediately force state ACC, acc=0, cnt=0, sat flag=0, out_valid=0, out_sum=0 and out_sat=0, regardless of clk.
REQ-030 Reset asserted mid-window or in HOLD SHALL discard all partial and pending results.
REQ-031 The first acceptance after release SHALL occur on the first rising edge with rst_n=1 and in_valid=1.

Verification
REQ-032 Scenario, basic window: LEN=9, ACC_W=10, nine products +9 back-to-back -> out_valid=1 the cycle after the 9th, out_sum=81, out_sat=0, in_ready=0.
REQ-033 Scenario, saturation: ACC_W=6, nine products -12 -> out_sum=-32, out_sat=1; the next window of nine +1 products -> out_sum=9, out_sat=0.
REQ-034 Scenario, backpressure: out_ready held 0 for 5 cycles after out_valid, with in_valid=1 throughout -> out_sum stable, no products consumed, and out_ready=1 then returns to ACC with cnt=0.
REQ-035 Scenario, bubbles: products +3,-4,(gap),+2,... totalling 9 accepted with random in_valid gaps -> sum matches a reference model and count is exactly 9.
REQ-036 Scenario, clr mid-window: after 4 products, clr=1 together with in_valid=1 -> acc=0 and cnt=0; the next 9 products of +1 -> out_sum=9.
REQ-037 Scenario, async reset: rst_n pulsed low between clk edges while in HOLD -> out_valid=0 and out_sum=0 without a clock edge, and in_ready=1.
